// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: response record carried down the latency pipe.
// DMEM_LAT_MAX bounds the pipe depth and sizes the outstanding counter.
package data_mem_responder_pkg;

  localparam int DMEM_LAT_MAX = 8;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } dmem_resp_t;

endpackage

// File: rtl/data_mem_responder_pipe.sv
// Fixed-latency response shift pipe: a record pushed at edge k is at the head after edge k+LATENCY-1.
// Reset clears every stage, so in-flight responses are dropped.
module dmem_resp_pipe
  import data_mem_responder_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  dmem_resp_t i_push,
  output dmem_resp_t o_head
);

  dmem_resp_t r_stage [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_push;
      for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_head = r_stage[LATENCY-1];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word SRAM with byte-enable stores and in-order fixed-latency responses.
// Optional pseudo-random grant stalls when DATA_MEM_RESP_RANDOM_STALL_EN is defined.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(DMEM_LAT_MAX + 2);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [CW-1:0] r_out_cnt;
  logic [31:0]   w_off;
  logic [31:0]   w_word;
  logic [AW-1:0] w_idx;
  logic          w_err;
  logic          w_stall;
  logic          w_gnt;
  dmem_resp_t    w_push;
  dmem_resp_t    w_head;

  assign w_off  = data_addr_i - BASE_ADDR;
  assign w_word = w_off >> 2;
  assign w_idx  = w_word[AW-1:0];
  assign w_err  = (data_addr_i < BASE_ADDR) | (w_word >= 32'(DEPTH_WORDS)) |
                  (data_addr_i[1:0] != 2'b00);

`ifdef DATA_MEM_RESP_RANDOM_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= 16'hACE1;
    else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // Grant is held low during reset so nothing is accepted while the pipe is being cleared.
  assign w_gnt      = data_req_i & ~rst & (r_out_cnt < MAX_C) & ~w_stall;
  assign data_gnt_o = w_gnt;

  always_comb begin
    w_push       = '0;
    w_push.valid = w_gnt;
    w_push.err   = w_gnt & w_err;
    if (w_gnt & ~data_we_i & ~w_err) w_push.rdata = r_mem[w_idx];
  end

  always_ff @(posedge clk) begin
    if (w_gnt & data_we_i & ~w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) r_mem[w_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_cnt <= '0;
    end else begin
      case ({w_gnt, w_head.valid})
        2'b10:   r_out_cnt <= r_out_cnt + CW'(1);
        2'b01:   r_out_cnt <= r_out_cnt - CW'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

  dmem_resp_pipe #(
    .LATENCY(LATENCY)
  ) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_push(w_push),
    .o_head(w_head)
  );

  assign data_rvalid_o = w_head.valid;
  assign data_rdata_o  = w_head.rdata;
  assign data_err_o    = w_head.err;

endmodule
